// File: rtl/demorgan_sweep_pkg.sv
// rtl/demorgan_sweep_pkg.sv - shared states and fault-injection encodings for the De Morgan sweep
package demorgan_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] FAULT_NONE = 2'd0;
   localparam logic [1:0] FAULT_LAW1 = 2'd1;
   localparam logic [1:0] FAULT_LAW2 = 2'd2;
   localparam logic [1:0] FAULT_BOTH = 2'd3;

endpackage

// File: rtl/demorgan_slice.sv
// rtl/demorgan_slice.sv - combinational evaluation of both De Morgan laws for one operand pair
module demorgan_slice
   import demorgan_sweep_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_fault,
   output logic [WIDTH-1:0] o_l1a,
   output logic [WIDTH-1:0] o_l1b,
   output logic [WIDTH-1:0] o_l2a,
   output logic [WIDTH-1:0] o_l2b
);

   logic w_inj1;
   logic w_inj2;

   assign w_inj1 = (i_fault == FAULT_LAW1) || (i_fault == FAULT_BOTH);
   assign w_inj2 = (i_fault == FAULT_LAW2) || (i_fault == FAULT_BOTH);

   // Injected faults flip only bit 0 of the expanded (right-hand) form of each law.
   assign o_l1a = ~(i_a & i_b);
   assign o_l1b = (~i_a | ~i_b) ^ WIDTH'(w_inj1);
   assign o_l2a = ~(i_a | i_b);
   assign o_l2b = (~i_a & ~i_b) ^ WIDTH'(w_inj2);

endmodule

// File: rtl/demorgan_sweep.sv
// rtl/demorgan_sweep.sv - exhaustive operand sweep counting De Morgan law mismatches
module demorgan_sweep
   import demorgan_sweep_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           fault_inj,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [WIDTH-1:0]     a_cur,
   output logic [WIDTH-1:0]     b_cur,
   output logic [2*WIDTH+1:0]   err_count
);

   localparam int VW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 2;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [VW-1:0]    r_vec;
   logic [EW-1:0]    r_err;
   logic [1:0]       r_fault;
   logic             r_m1;
   logic             r_m2;

   logic             w_last;
   logic             w_accept;
   logic             w_m1;
   logic             w_m2;
   logic [WIDTH-1:0] w_l1a;
   logic [WIDTH-1:0] w_l1b;
   logic [WIDTH-1:0] w_l2a;
   logic [WIDTH-1:0] w_l2b;

   demorgan_slice #(.WIDTH(WIDTH)) u_slice (
      .i_a     (r_vec[VW-1:WIDTH]),
      .i_b     (r_vec[WIDTH-1:0]),
      .i_fault (r_fault),
      .o_l1a   (w_l1a),
      .o_l1b   (w_l1b),
      .o_l2a   (w_l2a),
      .o_l2b   (w_l2b)
   );

   assign w_m1     = (w_l1a != w_l1b);
   assign w_m2     = (w_l2a != w_l2b);
   assign w_last   = &r_vec;
   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_SWEEP;
         ST_SWEEP: if (w_last) w_state_nxt = ST_FLUSH;
         ST_FLUSH: w_state_nxt = ST_DONE;
         ST_DONE:  if (start) w_state_nxt = ST_SWEEP;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_err   <= '0;
         r_fault <= FAULT_NONE;
         r_m1    <= 1'b0;
         r_m2    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_vec   <= '0;
            r_err   <= '0;
            r_fault <= fault_inj;
            r_m1    <= 1'b0;
            r_m2    <= 1'b0;
         end else begin
            if ((r_state == ST_SWEEP) && !w_last)
               r_vec <= r_vec + VW'(1);
            // Flags lag the vector by one cycle; FLUSH drains the last one into the count.
            r_err <= r_err + EW'(r_m1) + EW'(r_m2);
            r_m1  <= (r_state == ST_SWEEP) && w_m1;
            r_m2  <= (r_state == ST_SWEEP) && w_m2;
         end
      end
   end

   assign busy      = (r_state == ST_SWEEP) || (r_state == ST_FLUSH);
   assign done      = (r_state == ST_DONE);
   assign pass      = (r_state == ST_DONE) && (r_err == '0);
   assign a_cur     = r_vec[VW-1:WIDTH];
   assign b_cur     = r_vec[WIDTH-1:0];
   assign err_count = r_err;

endmodule

// File: doc/demorgan_sweep.md
DEMORGAN_SWEEP -- requirements
Module: demorgan_sweep

Interface
REQ-001 Parameter WIDTH, default 4, legal range 1..8; operand width in bits.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, reset is synchronous and active-high.
REQ-004 Port start, input, 1, begins a sweep when sampled high in IDLE or DONE.
REQ-005 Port fault_inj, input, 2, fault-injection select; sampled only when a sweep is accepted.
REQ-006 Port busy, output, 1, high during SWEEP and FLUSH.
REQ-007 Port done, output, 1, high in DONE only.
REQ-008 Port pass, output, 1, high in DONE when err_count is zero; low otherwise.
REQ-009 Port a_cur, output, WIDTH, operand A of the vector currently applied.
REQ-010 Port b_cur, output, WIDTH, operand B of the vector currently applied.
REQ-011 Port err_count, output, 2*WIDTH+2, accumulated mismatch count.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SWEEP, FLUSH and DONE.
REQ-013 IDLE->SWEEP and DONE->SWEEP on start=1: the vector counter {a_cur,b_cur} clears to 0, err_count clears, and fault_inj latches.
REQ-014 In SWEEP the vector counter SHALL increment by 1 each cycle, with a_cur as the MSBs, visiting all 2^(2*WIDTH) vectors exactly once.
REQ-015 SWEEP->FLUSH on the cycle the counter holds all-ones; the counter SHALL hold all-ones and SHALL NOT wrap.
REQ-016 FLUSH->DONE unconditionally after one cycle; DONE holds until start or reset.
REQ-017 start in SWEEP or FLUSH SHALL be ignored; no restart and no counter disturbance.
REQ-018 Per vector, compute bitwise form L1a=~(A&B), L1b=~A|~B, L2a=~(A|B), L2b=~A&~B.
REQ-019 Latched fault_inj[0]=1 SHALL invert bit 0 of L1b; fault_inj[1]=1 SHALL invert bit 0 of L2b.
REQ-020 Mismatch flags m1=(L1a!=L1b) and m2=(L2a!=L2b) SHALL be registered in one pipeline stage.
REQ-021 err_count SHALL add m1+m2 (0, 1 or 2) one cycle after the vector is applied; the FLUSH cycle accounts for the last vector.
REQ-022 err_count width SHALL hold the maximum 2^(2*WIDTH+1) without overflow; no saturation logic is required.
REQ-023 Pipeline mismatch flags SHALL be zero in IDLE and DONE so that err_count is stable there.
REQ-024 Sweep length SHALL be 2^(2*WIDTH) SWEEP cycles plus 1 FLUSH cycle, with done rising the next cycle.

Reset
REQ-025 On reset=1 at a clock edge: state IDLE, busy=0, done=0, pass=0, a_cur=0, b_cur=0, err_count=0, pipeline flags=0, latched fault=0.
REQ-026 Reset SHALL override start and any in-progress sweep, including mid-SWEEP and FLUSH; no partial count survives.
REQ-027 Reset SHALL dominate start when both are high in the same cycle.

Structure
REQ-028 A shared package SHALL hold the state enumeration and named constants for the fault_inj encodings (NONE=0, LAW1=1, LAW2=2, BOTH=3).
REQ-029 The combinational per-vector logic of REQ-018 and REQ-019 SHALL be a sub-module demorgan_slice, parametrised by WIDTH.
REQ-030 demorgan_slice SHALL output L1a, L1b, L2a and L2b, and SHALL be instantiated once.

Verification
REQ-031 WIDTH=4, fault_inj=0, single-cycle start -> busy for 257 cycles, then done=1, pass=1, err_count=0.
REQ-032 WIDTH=4, fault_inj=1 -> err_count=256, pass=0; fault_inj=2 -> 256; fault_inj=3 -> 512.
REQ-033 WIDTH=1, fault_inj=3 -> a_cur/b_cur visit 00, 01, 10, 11 in order; err_count=8; done rises 5 cycles after start.
REQ-034 Reset asserted mid-SWEEP at vector 0x37, with start held high the same cycle -> next cycle IDLE, all outputs 0.
REQ-035 Mid-sweep start pulse and fault_inj change -> sweep completes unaltered with the originally latched fault result.
REQ-036 Start in DONE with new fault_inj -> err_count clears and the new sweep's total matches REQ-032.
